// File: rtl/rcpu_datapath_hs_pkg.sv
// Shared encodings for the handshaked RCPU datapath:
// operand/address source selects and memory FSM states.
package rcpu_datapath_hs_pkg;

  typedef enum logic [1:0] {
    ALUA_ZERO = 2'd0,
    ALUA_REG  = 2'd1,
    ALUA_PC   = 2'd2,
    ALUA_V    = 2'd3
  } alua_src_e;

  typedef enum logic [2:0] {
    ALUB_ZERO  = 3'd0,
    ALUB_REG   = 3'd1,
    ALUB_SEXT8 = 3'd2,
    ALUB_ZEXT  = 3'd3,
    ALUB_ONE   = 3'd4
  } alub_src_e;

  typedef enum logic [1:0] {
    ADDR_PC   = 2'd0,
    ADDR_REG  = 2'd1,
    ADDR_ALU  = 2'd2,
    ADDR_PC2  = 2'd3
  } addr_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic WDATA_ALU = 1'b0;
  localparam logic WDATA_R   = 1'b1;

  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rcpu_datapath_hs_regfile.sv
// 2R/1W register file; out-of-range selects read 0
// and never write.
module rcpu_regfile #(
  parameter int M    = 16,
  parameter int NREG = 4,
  parameter int RS   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RS-1:0] wsel,
  input  logic [M-1:0]  wdata,
  input  logic [RS-1:0] asel,
  input  logic [RS-1:0] bsel,
  output logic [M-1:0]  adata,
  output logic [M-1:0]  bdata
);

  logic [M-1:0] mem_q [NREG];
  logic [M-1:0] mem_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
      if (we && wsel == RS'(i)) mem_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    adata = '0;
    bdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (asel == RS'(i)) adata = mem_q[i];
      if (bsel == RS'(i)) bdata = mem_q[i];
    end
  end

endmodule

// File: rtl/rcpu_register.sv
// Enabled W-bit register with async active-low clear.
module rcpu_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rcpu_datapath_hs.sv
// RCPU datapath with req/ack memory handshake,
// controller stall and sticky bus timeout.
module rcpu_datapath_hs
  import rcpu_datapath_hs_pkg::*;
#(
  parameter int M       = 16,
  parameter int NREG    = 4,
  parameter int TIMEOUT = 15,
  parameter int RS      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctrl_en_ir,
  input  logic          ctrl_en_v,
  input  logic          ctrl_en_r,
  input  logic          ctrl_en_pc,
  input  logic          ctrl_reg_we,
  input  logic [RS-1:0] ctrl_wsel,
  input  logic [RS-1:0] ctrl_asel,
  input  logic [RS-1:0] ctrl_bsel,
  input  logic [1:0]    ctrl_alua_src,
  input  logic [2:0]    ctrl_alub_src,
  input  logic [1:0]    ctrl_addr_src,
  input  logic          ctrl_wdata_src,
  input  logic          ctrl_mem_rd,
  input  logic          ctrl_mem_wr,
  input  logic          ctrl_en_f,
  input  logic          ctrl_src_f,
  input  logic [3:0]    ctrl_alt_f,
  output logic [M-1:0]  alu_a,
  output logic [M-1:0]  alu_b,
  input  logic [M-1:0]  alu_y,
  input  logic [3:0]    alu_flags,
  output logic [M-1:0]  opcode,
  output logic [3:0]    flags,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [M-1:0]  mem_addr,
  output logic [M-1:0]  mem_wdata,
  input  logic [M-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [M-1:0]  addr_q, addr_d;
  logic [M-1:0]  wdata_q, wdata_d;
  logic          berr_q, berr_d;

  logic [M-1:0] pc_q, ir_q, v_q, r_q;
  logic [3:0]   f_q, f_in;
  logic [M-1:0] ra, rb, addr_sel, wdata_sel;
  logic         done, timeout, rd_done;

  always_comb begin
    unique case (addr_src_e'(ctrl_addr_src))
      ADDR_REG: addr_sel = ra;
      ADDR_ALU: addr_sel = alu_y;
      default:  addr_sel = pc_q;
    endcase
    wdata_sel = (ctrl_wdata_src == WDATA_R) ? r_q : alu_y;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    berr_d  = berr_q;
    stall   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_mem_rd || ctrl_mem_wr) begin
          stall   = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = ctrl_mem_wr;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
        end
      end
      ST_BUSY: begin
        cnt_d   = cnt_q + CW'(1);
        timeout = (TIMEOUT != 0) && (cnt_d == CW'(TIMEOUT));
        // ack in the timeout cycle still completes normally
        if (mem_ack) begin
          done    = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (timeout) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      berr_q  <= berr_d;
    end
  end

  assign rd_done = done & ~we_q;
  assign f_in    = ctrl_src_f ? ctrl_alt_f : alu_flags;

  rcpu_regfile #(.M(M), .NREG(NREG), .RS(RS)) u_rf (
    .clk   (clk),
    .rst_n (rst),
    .we    (ctrl_reg_we & ~stall),
    .wsel  (ctrl_wsel),
    .wdata (alu_y),
    .asel  (ctrl_asel),
    .bsel  (ctrl_bsel),
    .adata (ra),
    .bdata (rb)
  );

  rcpu_register #(.W(M)) u_pc (
    .clk(clk), .rst_n(rst), .en(ctrl_en_pc & ~stall),
    .d(alu_y), .q(pc_q)
  );

  rcpu_register #(.W(M)) u_r (
    .clk(clk), .rst_n(rst), .en(ctrl_en_r & ~stall),
    .d(alu_y), .q(r_q)
  );

  rcpu_register #(.W(M)) u_ir (
    .clk(clk), .rst_n(rst), .en(rd_done & ctrl_en_ir),
    .d(mem_rdata), .q(ir_q)
  );

  rcpu_register #(.W(M)) u_v (
    .clk(clk), .rst_n(rst), .en(rd_done & ctrl_en_v),
    .d(mem_rdata), .q(v_q)
  );

  rcpu_register #(.W(4)) u_f (
    .clk(clk), .rst_n(rst), .en(ctrl_en_f & ~stall),
    .d(f_in), .q(f_q)
  );

  always_comb begin
    unique case (alua_src_e'(ctrl_alua_src))
      ALUA_REG: alu_a = ra;
      ALUA_PC:  alu_a = pc_q;
      ALUA_V:   alu_a = v_q;
      default:  alu_a = '0;
    endcase
    case (alub_src_e'(ctrl_alub_src))
      ALUB_REG:   alu_b = rb;
      ALUB_SEXT8: alu_b = {{(M-8){ir_q[7]}}, ir_q[7:0]};
      ALUB_ZEXT:  alu_b = {1'b0, ir_q[M-2:0]};
      ALUB_ONE:   alu_b = M'(1);
      default:    alu_b = '0;
    endcase
  end

  assign opcode    = ir_q;
  assign flags     = f_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_rcpu_datapath_hs.sv
// Directed bench for rcpu_datapath_hs: handshake, timeout,
// operand muxes, register file and flags.
module tb_rcpu_datapath_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_en_ir, ctrl_en_v, ctrl_en_r, ctrl_en_pc;
  logic        ctrl_reg_we;
  logic [2:0]  ctrl_wsel, ctrl_asel, ctrl_bsel;
  logic [1:0]  ctrl_alua_src;
  logic [2:0]  ctrl_alub_src;
  logic [1:0]  ctrl_addr_src;
  logic        ctrl_wdata_src;
  logic        ctrl_mem_rd, ctrl_mem_wr;
  logic        ctrl_en_f, ctrl_src_f;
  logic [3:0]  ctrl_alt_f;
  logic [15:0] alu_y;
  logic [3:0]  alu_flags;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic [15:0] alu_a, alu_b, opcode, mem_addr, mem_wdata;
  logic [3:0]  flags;
  logic        stall, mem_req, mem_we, bus_err;

  logic [15:0] alu_a_6, alu_b_6, opcode_6, mem_addr_6, mem_wdata_6;
  logic [3:0]  flags_6;
  logic        stall_6, mem_req_6, mem_we_6, bus_err_6;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rcpu_datapath_hs #(.M(16), .NREG(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ctrl_en_ir(ctrl_en_ir), .ctrl_en_v(ctrl_en_v),
    .ctrl_en_r(ctrl_en_r), .ctrl_en_pc(ctrl_en_pc),
    .ctrl_reg_we(ctrl_reg_we), .ctrl_wsel(ctrl_wsel),
    .ctrl_asel(ctrl_asel), .ctrl_bsel(ctrl_bsel),
    .ctrl_alua_src(ctrl_alua_src), .ctrl_alub_src(ctrl_alub_src),
    .ctrl_addr_src(ctrl_addr_src), .ctrl_wdata_src(ctrl_wdata_src),
    .ctrl_mem_rd(ctrl_mem_rd), .ctrl_mem_wr(ctrl_mem_wr),
    .ctrl_en_f(ctrl_en_f), .ctrl_src_f(ctrl_src_f),
    .ctrl_alt_f(ctrl_alt_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_flags(alu_flags), .opcode(opcode), .flags(flags),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  rcpu_datapath_hs #(.M(16), .NREG(6), .TIMEOUT(4)) dut6 (
    .clk(clk), .rst(rst),
    .ctrl_en_ir(ctrl_en_ir), .ctrl_en_v(ctrl_en_v),
    .ctrl_en_r(ctrl_en_r), .ctrl_en_pc(ctrl_en_pc),
    .ctrl_reg_we(ctrl_reg_we), .ctrl_wsel(ctrl_wsel),
    .ctrl_asel(ctrl_asel), .ctrl_bsel(ctrl_bsel),
    .ctrl_alua_src(ctrl_alua_src), .ctrl_alub_src(ctrl_alub_src),
    .ctrl_addr_src(ctrl_addr_src), .ctrl_wdata_src(ctrl_wdata_src),
    .ctrl_mem_rd(ctrl_mem_rd), .ctrl_mem_wr(ctrl_mem_wr),
    .ctrl_en_f(ctrl_en_f), .ctrl_src_f(ctrl_src_f),
    .ctrl_alt_f(ctrl_alt_f),
    .alu_a(alu_a_6), .alu_b(alu_b_6), .alu_y(alu_y),
    .alu_flags(alu_flags), .opcode(opcode_6), .flags(flags_6),
    .stall(stall_6), .mem_req(mem_req_6), .mem_we(mem_we_6),
    .mem_addr(mem_addr_6), .mem_wdata(mem_wdata_6),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err_6)
  );

  typedef struct {
    logic [1:0]  as;
    logic [2:0]  bs;
    logic [2:0]  asel;
    logic [2:0]  bsel;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ctrl_en_ir = 0; ctrl_en_v = 0; ctrl_en_r = 0; ctrl_en_pc = 0;
    ctrl_reg_we = 0; ctrl_wsel = 0; ctrl_asel = 0; ctrl_bsel = 0;
    ctrl_alua_src = 0; ctrl_alub_src = 0; ctrl_addr_src = 0;
    ctrl_wdata_src = 0; ctrl_mem_rd = 0; ctrl_mem_wr = 0;
    ctrl_en_f = 0; ctrl_src_f = 0; ctrl_alt_f = 0;
  endtask

  // request cycle, then waits BUSY cycles without ack, then ack
  task automatic run_access(input int waits, input logic [15:0] rd,
                            output int stalls);
    stalls = 0;
    #1 if (stall) stalls++;
    tick();
    for (int i = 0; i < waits; i++) begin
      if (stall) stalls++;
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    #1 if (stall) stalls++;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{2'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    tbl[1] = '{2'd1, 3'd1, 3'd1, 3'd2, 16'h0200, 16'h1111};
    tbl[2] = '{2'd2, 3'd2, 3'd0, 3'd0, 16'h0010, 16'hFFF0};
    tbl[3] = '{2'd3, 3'd4, 3'd0, 3'd0, 16'h5A5A, 16'h0001};
    tbl[4] = '{2'd1, 3'd3, 3'd3, 3'd0, 16'h3333, 16'h00F0};
    tbl[5] = '{2'd1, 3'd5, 3'd2, 3'd1, 16'h1111, 16'h0000};
    tbl[6] = '{2'd0, 3'd6, 3'd0, 3'd0, 16'h0000, 16'h0000};
    tbl[7] = '{2'd1, 3'd7, 3'd4, 3'd1, 16'h0000, 16'h0000};
    tbl[8] = '{2'd0, 3'd1, 3'd0, 3'd3, 16'h0000, 16'h3333};

    clr();
    rst = 0; mem_ack = 0; mem_rdata = 0; alu_y = 0; alu_flags = 0;
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_flags", flags, 0);
    rst = 1;
    tick();

    ctrl_reg_we = 1; ctrl_wsel = 1; alu_y = 16'h0200; tick();
    ctrl_wsel = 2; alu_y = 16'h1111; tick();
    clr(); ctrl_en_pc = 1; alu_y = 16'h0010; tick();
    clr(); ctrl_en_r = 1; alu_y = 16'hBEEF; tick();
    clr(); alu_y = 16'h0000;

    // read into IR, ack on third BUSY cycle
    ctrl_mem_rd = 1; ctrl_en_ir = 1; ctrl_addr_src = 0;
    run_access(2, 16'h8123, n);
    chk("rd_stalls", n, 3);
    chk("rd_addr", mem_addr, 16'h0010);
    chk("rd_we", mem_we, 0);
    chk("rd_req_off", mem_req, 0);
    chk("rd_opcode", opcode, 16'h8123);
    clr(); ctrl_alua_src = 2;
    #1 chk("rd_pc_kept", alu_a, 16'h0010);

    // write R to reg[1] address; reg[3] write held off by stall
    clr();
    ctrl_mem_wr = 1; ctrl_wdata_src = 1; ctrl_addr_src = 1;
    ctrl_asel = 1; ctrl_reg_we = 1; ctrl_wsel = 3; alu_y = 16'h3333;
    ctrl_alub_src = 1; ctrl_bsel = 3;
    #1 chk("wr_stall_idle", stall, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("wr_req", mem_req, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 16'h0200);
      chk("wr_wdata", mem_wdata, 16'hBEEF);
      chk("wr_reg_held", alu_b, 16'h0000);
      tick();
    end
    mem_ack = 1;
    #1 chk("wr_stall_ack", stall, 0);
    tick();
    mem_ack = 0;
    clr(); ctrl_alub_src = 1; ctrl_bsel = 3;
    #1 chk("wr_reg_commit", alu_b, 16'h3333);
    chk("wr_req_off", mem_req, 0);

    // ack in the timeout cycle wins
    clr(); ctrl_mem_rd = 1; ctrl_en_v = 1;
    run_access(3, 16'h5A5A, n);
    chk("ack4_stalls", n, 4);
    chk("ack4_berr", bus_err, 0);
    clr(); ctrl_alua_src = 3;
    #1 chk("ack4_v", alu_a, 16'h5A5A);

    // no ack: timeout after 4 BUSY cycles
    clr(); ctrl_mem_rd = 1; ctrl_en_v = 1; mem_rdata = 16'hDEAD;
    #1 chk("to_stall_idle", stall, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("to_stall_busy", stall, 1);
      tick();
    end
    chk("to_stall_rel", stall, 0);
    chk("to_req_last", mem_req, 1);
    tick();
    chk("to_req_off", mem_req, 0);
    chk("to_berr", bus_err, 1);
    clr(); ctrl_alua_src = 3;
    #1 chk("to_v_kept", alu_a, 16'h5A5A);
    chk("to_stall_after", stall, 0);

    // immediate-ack read loads IR; bus_err stays set
    clr(); ctrl_mem_rd = 1; ctrl_en_ir = 1;
    run_access(0, 16'h00F0, n);
    chk("fast_stalls", n, 1);
    chk("berr_sticky", bus_err, 1);
    clr();

    for (int i = 0; i < 9; i++) begin
      ctrl_alua_src = tbl[i].as;
      ctrl_alub_src = tbl[i].bs;
      ctrl_asel = tbl[i].asel;
      ctrl_bsel = tbl[i].bsel;
      #1;
      chk($sformatf("tbl%0d_a", i), alu_a, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i), alu_b, tbl[i].eb);
    end

    // alu_y address source, IR = 0xFFFF
    clr(); ctrl_mem_rd = 1; ctrl_en_ir = 1; ctrl_addr_src = 2;
    alu_y = 16'h0ABC;
    run_access(1, 16'hFFFF, n);
    chk("aluy_addr", mem_addr, 16'h0ABC);
    clr(); ctrl_alub_src = 3;
    #1 chk("zext_ffff", alu_b, 16'h7FFF);
    ctrl_alub_src = 2;
    #1 chk("sext_ffff", alu_b, 16'hFFFF);

    // read-during-write returns old value
    clr(); ctrl_reg_we = 1; ctrl_wsel = 7; alu_y = 16'h1234;
    ctrl_asel = 7; ctrl_alua_src = 1;
    #1 chk("rdw_old", alu_a, 16'h0000);
    tick();
    chk("rdw_new", alu_a, 16'h1234);

    // reg[6] exists only in the 8-entry instance
    clr(); ctrl_reg_we = 1; ctrl_wsel = 6; alu_y = 16'h7777;
    tick();
    clr(); ctrl_alua_src = 1; ctrl_asel = 6;
    #1 chk("n8_reg6", alu_a, 16'h7777);
    chk("n6_reg6", alu_a_6, 16'h0000);
    ctrl_asel = 2;
    #1 chk("n6_reg2", alu_a_6, 16'h1111);
    ctrl_asel = 5;
    #1 chk("n6_reg5", alu_a_6, 16'h0000);

    clr(); ctrl_en_f = 1; ctrl_src_f = 1; ctrl_alt_f = 4'hA;
    alu_flags = 4'h5;
    tick();
    chk("flags_alt", flags, 4'hA);
    ctrl_src_f = 0;
    tick();
    chk("flags_alu", flags, 4'h5);

    // reset in the middle of an access
    clr(); ctrl_mem_rd = 1; ctrl_en_ir = 1;
    tick();
    chk("mid_req", mem_req, 1);
    #2 rst = 0;
    #1;
    chk("mid_req_drop", mem_req, 0);
    chk("mid_opcode", opcode, 0);
    chk("mid_flags", flags, 0);
    chk("mid_berr", bus_err, 0);
    chk("mid_addr", mem_addr, 0);
    clr(); ctrl_alua_src = 2;
    #1 chk("mid_pc", alu_a, 0);
    ctrl_alua_src = 1; ctrl_asel = 1;
    #1 chk("mid_reg1", alu_a, 0);
    rst = 1;
    #1 chk("post_stall", stall, 0);
    tick();
    chk("post_stall_clk", stall, 0);
    chk("post_req", mem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
